tap_recorder: RTL and testbench

- Tape-save decoder: the recording counterpart of the TAP playback loader.
- Watches the CPU's MIC-out level (port FE bit D3) and measures half-periods in CPU T-states.
- Decodes the ROM SAVE pulse stream (pilot, sync, bits) into bytes.
- Writes the bytes into the TAP memory as standard TAP blocks (2-byte little-endian length + data), so a saved program can later be replayed by the tape loader.

---
 rtl/tap_recorder_pkg.sv | 45 ++++
 rtl/tap_recorder_if.sv | 11 +
 rtl/tap_recorder_classifier.sv | 51 +++++
 rtl/tap_recorder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_tap_recorder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tap_recorder_pkg.sv
// Shared types and timing constants for the tape-save recorder.
// Nominal ROM SAVE half-period lengths are in CPU T-states.
package tap_rec_pkg;

    localparam int CNT_W   = 13;
    localparam int T_PILOT = 2168;
    localparam int T_SYNC1 = 667;
    localparam int T_SYNC2 = 735;
    localparam int T_ZERO  = 855;
    localparam int T_ONE   = 1710;

    typedef enum logic [2:0] {
        CLS_SYNC,
        CLS_ZERO,
        CLS_ONE,
        CLS_PILOT,
        CLS_LONG
    } pulse_cls_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PILOT,
        ST_PILOT,
        ST_SYNC,
        ST_DATA,
        ST_COMMIT_LO,
        ST_COMMIT_HI
    } rec_state_e;

    // Thresholds are inclusive upper bounds, checked shortest first.
    function automatic pulse_cls_e classify(input logic [CNT_W-1:0] v,
                                            input int sync_max,
                                            input int zero_max,
                                            input int one_max,
                                            input int pilot_max);
        int vi;
        vi = int'(v);
        if (vi <= sync_max)       return CLS_SYNC;
        else if (vi <= zero_max)  return CLS_ZERO;
        else if (vi <= one_max)   return CLS_ONE;
        else if (vi <= pilot_max) return CLS_PILOT;
        else                      return CLS_LONG;
    endfunction

endpackage

// File: rtl/tap_recorder_if.sv
// TAP memory write port: the recorder drives, the memory listens.
interface tap_recorder_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] tap_wr_addr;
    logic [7:0]        tap_wr_data;
    logic              tap_wr_en;

    modport master (output tap_wr_addr, output tap_wr_data, output tap_wr_en);
    modport slave  (input  tap_wr_addr, input  tap_wr_data, input  tap_wr_en);
endinterface

// File: rtl/tap_recorder_classifier.sv
// MIC edge detector and half-period timer; classifies each half-period on
// the edge that ends it and flags a silence timeout once.
module tap_pulse_classifier
    import tap_rec_pkg::*;
#(
    parameter int SYNC_MAX  = 780,
    parameter int ZERO_MAX  = 1282,
    parameter int ONE_MAX   = 1939,
    parameter int PILOT_MAX = 2600,
    parameter int TIMEOUT_T = 7000
) (
    input  logic       clock_25,
    input  logic       RESET_N,
    input  logic       tstate_en_i,
    input  logic       mic_i,
    output logic       cls_vld_o,
    output pulse_cls_e cls_o,
    output logic       timeout_o
);

    logic             mic_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mic_edge;

    assign mic_edge = mic_i ^ mic_prev_q;

    // An edge reloads to 0 even when a T-state strobe lands in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (mic_edge)
            cnt_d = '0;
        else if (tstate_en_i && (cnt_q != CNT_W'(TIMEOUT_T)))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            mic_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mic_prev_q <= mic_i;
            cnt_q      <= cnt_d;
        end
    end

    assign cls_vld_o = mic_edge;
    assign cls_o     = classify(cnt_q, SYNC_MAX, ZERO_MAX, ONE_MAX, PILOT_MAX);
    // Fires on the single step into saturation, so it pulses once per silence.
    assign timeout_o = tstate_en_i && !mic_edge && (cnt_q == CNT_W'(TIMEOUT_T - 1));

endmodule

// File: rtl/tap_recorder.sv
// Tape-save decoder: turns the ROM SAVE pulse stream on MIC-out into TAP
// blocks (2-byte little-endian length + data) in the TAP memory.
module tap_recorder
    import tap_rec_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int SYNC_MAX  = 780,
    parameter int ZERO_MAX  = 1282,
    parameter int ONE_MAX   = 1939,
    parameter int PILOT_MAX = 2600,
    parameter int MIN_PILOT = 256,
    parameter int TIMEOUT_T = 7000
) (
    input  logic              clock_25,
    input  logic              RESET_N,
    input  logic              tstate_en,
    input  logic              mic_out,
    input  logic              arm,
    input  logic              clear,
    tap_recorder_if.master    wr,
    output logic [ADDR_W-1:0] tap_end,
    output logic [7:0]        block_count,
    output logic              parity_ok,
    output logic              busy,
    output logic              err,
    output logic              full
);

    // Pointers carry one extra bit so "one past the top" is representable.
    localparam int PW   = ADDR_W + 1;
    localparam int PC_W = $clog2(MIN_PILOT + 1);

    logic       cls_vld;
    pulse_cls_e cls;
    logic       timeout;

    tap_pulse_classifier #(
        .SYNC_MAX  (SYNC_MAX),
        .ZERO_MAX  (ZERO_MAX),
        .ONE_MAX   (ONE_MAX),
        .PILOT_MAX (PILOT_MAX),
        .TIMEOUT_T (TIMEOUT_T)
    ) u_cls (
        .clock_25    (clock_25),
        .RESET_N     (RESET_N),
        .tstate_en_i (tstate_en),
        .mic_i       (mic_out),
        .cls_vld_o   (cls_vld),
        .cls_o       (cls),
        .timeout_o   (timeout)
    );

    rec_state_e        state_q, state_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     blk_q, blk_d;
    logic [PW-1:0]     wp_q, wp_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              half_q, half_d;
    pulse_cls_e        first_q, first_d;
    logic [7:0]        sh_q, sh_d;
    logic [7:0]        par_q, par_d;
    logic              err_q, err_d;
    logic              full_q, full_d;
    logic              pok_q, pok_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;

    logic [ADDR_W-1:0] len_aw;
    logic [15:0]       len16;
    logic [7:0]        byte_w;

    assign len_aw = ADDR_W'(wp_q - blk_q - PW'(2));
    assign len16  = 16'(len_aw);
    assign byte_w = {sh_q[6:0], (cls == CLS_ONE)};

    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            ptr_q     <= '0;
            blk_q     <= '0;
            wp_q      <= '0;
            bit_cnt_q <= '0;
            half_q    <= 1'b0;
            first_q   <= CLS_SYNC;
            sh_q      <= '0;
            par_q     <= '0;
            err_q     <= 1'b0;
            full_q    <= 1'b0;
            pok_q     <= 1'b0;
            bcnt_q    <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            ptr_q     <= ptr_d;
            blk_q     <= blk_d;
            wp_q      <= wp_d;
            bit_cnt_q <= bit_cnt_d;
            half_q    <= half_d;
            first_q   <= first_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
            err_q     <= err_d;
            full_q    <= full_d;
            pok_q     <= pok_d;
            bcnt_q    <= bcnt_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        ptr_d     = ptr_q;
        blk_d     = blk_q;
        wp_d      = wp_q;
        bit_cnt_d = bit_cnt_q;
        half_d    = half_q;
        first_d   = first_q;
        sh_d      = sh_q;
        par_d     = par_q;
        err_d     = err_q;
        full_d    = full_q;
        pok_d     = pok_q;
        bcnt_d    = bcnt_q;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;

        if (clear) begin
            ptr_d   = '0;
            bcnt_d  = '0;
            err_d   = 1'b0;
            full_d  = 1'b0;
            pok_d   = 1'b0;
            state_d = arm ? ST_WAIT_PILOT : ST_IDLE;
        end else if (!arm) begin
            // Abort: ptr is untouched, so a half-written block is simply overwritten later.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_WAIT_PILOT;

                ST_WAIT_PILOT: begin
                    if (cls_vld && (cls == CLS_PILOT) && !full_q) begin
                        pcnt_d  = PC_W'(1);
                        state_d = ST_PILOT;
                    end
                end

                ST_PILOT: begin
                    if (cls_vld) begin
                        if (cls == CLS_PILOT) begin
                            if (pcnt_q < PC_W'(MIN_PILOT))
                                pcnt_d = pcnt_q + PC_W'(1);
                        end else if ((cls == CLS_SYNC) && (pcnt_q >= PC_W'(MIN_PILOT))) begin
                            state_d = ST_SYNC;
                        end else begin
                            state_d = ST_WAIT_PILOT;
                        end
                    end else if (timeout) begin
                        state_d = ST_WAIT_PILOT;
                    end
                end

                ST_SYNC: begin
                    if (cls_vld) begin
                        if (cls == CLS_SYNC) begin
                            state_d   = ST_DATA;
                            blk_d     = ptr_q;
                            wp_d      = ptr_q + PW'(2);
                            bit_cnt_d = '0;
                            half_d    = 1'b0;
                            sh_d      = '0;
                            par_d     = '0;
                        end else begin
                            state_d = ST_WAIT_PILOT;
                        end
                    end else if (timeout) begin
                        state_d = ST_WAIT_PILOT;
                    end
                end

                ST_DATA: begin
                    if (cls_vld) begin
                        if ((cls != CLS_ZERO) && (cls != CLS_ONE)) begin
                            err_d   = 1'b1;
                            state_d = ST_WAIT_PILOT;
                        end else if (!half_q) begin
                            half_d  = 1'b1;
                            first_d = cls;
                        end else if (cls != first_q) begin
                            err_d   = 1'b1;
                            state_d = ST_WAIT_PILOT;
                        end else begin
                            half_d    = 1'b0;
                            sh_d      = byte_w;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (wp_q[ADDR_W]) begin
                                    full_d  = 1'b1;
                                    state_d = ST_WAIT_PILOT;
                                end else begin
                                    wen_d   = 1'b1;
                                    waddr_d = wp_q[ADDR_W-1:0];
                                    wdata_d = byte_w;
                                    wp_d    = wp_q + PW'(1);
                                    par_d   = par_q ^ byte_w;
                                end
                            end
                        end
                    end else if (timeout) begin
                        if (wp_q != (blk_q + PW'(2))) begin
                            // Bits left over after the last whole byte are dropped.
                            if (half_q || (bit_cnt_q != 3'd0))
                                err_d = 1'b1;
                            state_d = ST_COMMIT_LO;
                        end else begin
                            state_d = ST_WAIT_PILOT;
                        end
                    end
                end

                ST_COMMIT_LO: begin
                    wen_d   = 1'b1;
                    waddr_d = blk_q[ADDR_W-1:0];
                    wdata_d = len16[7:0];
                    state_d = ST_COMMIT_HI;
                end

                ST_COMMIT_HI: begin
                    wen_d   = 1'b1;
                    waddr_d = blk_q[ADDR_W-1:0] + ADDR_W'(1);
                    wdata_d = len16[15:8];
                    ptr_d   = wp_q;
                    pok_d   = (par_q == 8'h00);
                    if (bcnt_q != 8'hFF)
                        bcnt_d = bcnt_q + 8'd1;
                    state_d = ST_WAIT_PILOT;
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign wr.tap_wr_en   = wen_q;
    assign wr.tap_wr_addr = waddr_q;
    assign wr.tap_wr_data = wdata_q;

    assign tap_end     = ptr_q[ADDR_W-1:0];
    assign block_count = bcnt_q;
    assign parity_ok   = pok_q;
    assign err         = err_q;
    assign full        = full_q;
    assign busy        = (state_q == ST_PILOT) || (state_q == ST_SYNC) || (state_q == ST_DATA) ||
                         (state_q == ST_COMMIT_LO) || (state_q == ST_COMMIT_HI);

endmodule

// File: tb/tb_tap_recorder.sv
// Scoreboard bench for tap_recorder: timings scaled 1/40 (thresholds and
// nominal pulses alike) so full pilot/sync/data blocks fit a short run.
`timescale 1ns/1ps
module tb_tap_recorder;
    import tap_rec_pkg::*;

    localparam int SC        = 40;
    localparam int SYNC_MAX  = 780 / SC;    // 19
    localparam int ZERO_MAX  = 1282 / SC;   // 32
    localparam int ONE_MAX   = 1939 / SC;   // 48
    localparam int PILOT_MAX = 2600 / SC;   // 65
    localparam int MIN_PILOT = 16;
    localparam int TIMEOUT_T = 7000 / SC;   // 175
    localparam int PW_N = T_PILOT / SC;     // 54
    localparam int S1_N = T_SYNC1 / SC;     // 16
    localparam int S2_N = T_SYNC2 / SC;     // 18
    localparam int ZW_N = T_ZERO / SC;      // 21
    localparam int OW_N = T_ONE / SC;       // 42
    localparam int NPIL = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tst = 1'b1;
    logic mic = 1'b0, arm = 1'b0, clr = 1'b0;
    logic mic_s = 1'b0, arm_s = 1'b0, clr_s = 1'b0;
    logic sel = 1'b0;

    logic [15:0] tap_end;
    logic [7:0]  bcnt;
    logic        pok, busy, err, full;
    logic [3:0]  tap_end_s;
    logic [7:0]  bcnt_s;
    logic        pok_s, busy_s, err_s, full_s;

    tap_recorder_if #(.ADDR_W(16)) wif ();
    tap_recorder_if #(.ADDR_W(4))  wif_s ();

    tap_recorder #(.ADDR_W(16), .SYNC_MAX(SYNC_MAX), .ZERO_MAX(ZERO_MAX), .ONE_MAX(ONE_MAX),
                   .PILOT_MAX(PILOT_MAX), .MIN_PILOT(MIN_PILOT), .TIMEOUT_T(TIMEOUT_T)) dut (
        .clock_25(clk), .RESET_N(rst_n), .tstate_en(tst), .mic_out(mic), .arm(arm), .clear(clr),
        .wr(wif.master), .tap_end(tap_end), .block_count(bcnt), .parity_ok(pok),
        .busy(busy), .err(err), .full(full));

    tap_recorder #(.ADDR_W(4), .SYNC_MAX(SYNC_MAX), .ZERO_MAX(ZERO_MAX), .ONE_MAX(ONE_MAX),
                   .PILOT_MAX(PILOT_MAX), .MIN_PILOT(MIN_PILOT), .TIMEOUT_T(TIMEOUT_T)) dut_s (
        .clock_25(clk), .RESET_N(rst_n), .tstate_en(tst), .mic_out(mic_s), .arm(arm_s), .clear(clr_s),
        .wr(wif_s.master), .tap_end(tap_end_s), .block_count(bcnt_s), .parity_ok(pok_s),
        .busy(busy_s), .err(err_s), .full(full_s));

    always #20 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];
    wr_t exp_s[$];
    logic [7:0] blk[$];
    int ptr_m = 0;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Writes are sampled on the falling edge and matched in order.
    always @(negedge clk) begin
        if (wif.tap_wr_en === 1'b1) begin
            if (exp_q.size() == 0) chk("wr_unexpected", {16'h0, wif.tap_wr_addr}, 32'hFFFF_FFFF);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wif.tap_wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wif.tap_wr_data), 32'(e.data));
            end
        end
        if (wif_s.tap_wr_en === 1'b1) begin
            if (exp_s.size() == 0) chk("wr_s_unexpected", {28'h0, wif_s.tap_wr_addr}, 32'hFFFF_FFFF);
            else begin
                wr_t e;
                e = exp_s.pop_front();
                chk("wr_s_addr", 32'(wif_s.tap_wr_addr), 32'(e.addr));
                chk("wr_s_data", 32'(wif_s.tap_wr_data), 32'(e.data));
            end
        end
    end

    task automatic push_exp(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        if (sel) exp_s.push_back(e);
        else     exp_q.push_back(e);
    endtask

    // Toggle then hold: the DUT measures exactly v for this half-period.
    task automatic half(input int v);
        @(negedge clk);
        if (sel) mic_s = ~mic_s;
        else     mic = ~mic;
        repeat (v) @(negedge clk);
    endtask

    task automatic close_silence();
        @(negedge clk);
        if (sel) mic_s = ~mic_s;
        else     mic = ~mic;
        repeat (TIMEOUT_T + 20) @(negedge clk);
    endtask

    task automatic header(input int npil, input int pw, input int s1, input int s2);
        repeat (npil) half(pw);
        half(s1);
        half(s2);
    endtask

    task automatic send_byte(input logic [7:0] b, input int zw, input int ow);
        for (int i = 7; i >= 0; i--) begin
            half(b[i] ? ow : zw);
            half(b[i] ? ow : zw);
        end
    endtask

    task automatic tx_block(input int pw, input int s1, input int s2, input int zw, input int ow);
        header(NPIL, pw, s1, s2);
        foreach (blk[i]) begin
            send_byte(blk[i], zw, ow);
            push_exp(ptr_m + 2 + i, int'(blk[i]));
        end
        push_exp(ptr_m, blk.size() & 255);
        push_exp(ptr_m + 1, (blk.size() >> 8) & 255);
        close_silence();
        ptr_m += blk.size() + 2;
    endtask

    task automatic chk_big(input string t, input int te, input int bc, input int pk, input int er);
        chk({t, "_tap_end"}, 32'(tap_end), 32'(te));
        chk({t, "_blocks"},  32'(bcnt),    32'(bc));
        chk({t, "_parity"},  32'(pok),     32'(pk));
        chk({t, "_err"},     32'(err),     32'(er));
        chk({t, "_busy"},    32'(busy),    32'd0);
        chk({t, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string t);
        chk({t, "_tap_end"}, 32'(tap_end), 0);
        chk({t, "_blocks"},  32'(bcnt), 0);
        chk({t, "_parity"},  32'(pok), 0);
        chk({t, "_busy"},    32'(busy), 0);
        chk({t, "_err"},     32'(err), 0);
        chk({t, "_full"},    32'(full), 0);
        chk({t, "_wr_en"},   32'(wif.tap_wr_en), 0);
        chk({t, "_wr_addr"}, 32'(wif.tap_wr_addr), 0);
        chk({t, "_wr_data"}, 32'(wif.tap_wr_data), 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        if (sel) clr_s = 1'b1; else clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        clr_s = 1'b0;
        if (!sel) ptr_m = 0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        arm = 1'b1;
        repeat (TIMEOUT_T + 20) @(negedge clk);

        // Block of FF,A5,5A at address 0.
        blk = '{8'hFF, 8'hA5, 8'h5A};
        tx_block(PW_N, S1_N, S2_N, ZW_N, OW_N);
        chk_big("blk1", 5, 1, 1, 0);
        pulse_clear();
        chk_big("clear1", 0, 0, 0, 0);

        // Pilot too short: sync refused, nothing recorded.
        header(10, PW_N, S1_N, S2_N);
        send_byte(8'h11, ZW_N, OW_N);
        close_silence();
        chk_big("short", 0, 0, 0, 0);

        // Third pair mismatched: error, block dropped, then a good 1-byte block.
        header(NPIL, PW_N, S1_N, S2_N);
        half(OW_N); half(OW_N);
        half(ZW_N); half(ZW_N);
        half(ZW_N); half(OW_N);
        close_silence();
        chk_big("badpair", 0, 0, 0, 1);
        blk = '{8'h7E};
        tx_block(PW_N, S1_N, S2_N, ZW_N, OW_N);
        chk_big("after_err", 3, 1, 0, 1);
        pulse_clear();
        chk("clear2_err", 32'(err), 0);

        // Back-to-back blocks; the second uses pulses at the class boundaries.
        blk = '{8'h12, 8'h34};
        tx_block(PW_N, S1_N, S2_N, ZW_N, OW_N);
        chk_big("b2b_1", 4, 1, 0, 0);
        blk = '{8'hC3, 8'h5A, 8'h99};
        tx_block(PILOT_MAX, SYNC_MAX, SYNC_MAX, ZERO_MAX, ONE_MAX);
        chk_big("b2b_2", 9, 2, 1, 0);

        // Reset in the middle of a data byte.
        header(NPIL, PW_N, S1_N, S2_N);
        repeat (5) begin half(ZW_N); half(ZW_N); end
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        repeat (TIMEOUT_T + 20) @(negedge clk);
        blk = '{8'h3C};
        tx_block(PW_N, S1_N, S2_N, ZW_N, OW_N);
        chk_big("fresh", 3, 1, 0, 0);

        // 16-byte memory: 15 data bytes overflow at the 15th.
        sel = 1'b1;
        arm_s = 1'b1;
        repeat (4) @(negedge clk);
        header(NPIL, PW_N, S1_N, S2_N);
        for (int i = 0; i < 15; i++) begin
            send_byte(8'(8'h10 + i), ZW_N, OW_N);
            if (i < 14) push_exp(2 + i, 8'h10 + i);
        end
        close_silence();
        chk("full_flag", 32'(full_s), 1);
        chk("full_tap_end", 32'(tap_end_s), 0);
        chk("full_blocks", 32'(bcnt_s), 0);
        chk("full_err", 32'(err_s), 0);
        chk("full_pending", 32'(exp_s.size()), 0);
        repeat (NPIL) half(PW_N);
        chk("full_ignores", 32'(busy_s), 0);
        close_silence();
        pulse_clear();
        chk("full_cleared", 32'(full_s), 0);
        chk("full_pending2", 32'(exp_s.size()), 0);
        chk("big_idle_pending", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
